// File: rtl/mem_bus_resp_pkg.sv
// mem_bus_resp_pkg: shared constants and types for the memory/IO responder.
//   IO_*         : IO map (UART TX data port, status/halt port)
//   ST_*         : uart_tx serializer state encodings
//   mem_req_t    : one bus request as presented by the memory controller
//   rsp_sel_e    : which source drives the registered read-data bus
package mem_bus_resp_pkg;

  // Everything at or above IO_BASE is IO space; below it aliases into RAM.
  localparam logic [31:0] IO_BASE        = 32'h0003_0000;
  localparam logic [31:0] IO_TX_ADDR     = 32'h0003_0000;
  localparam logic [31:0] IO_STATUS_ADDR = 32'h0003_0004;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  din;
    logic        w_en;
  } mem_req_t;

  typedef enum logic [1:0] {
    RSP_ZERO   = 2'd0,
    RSP_RAM    = 2'd1,
    RSP_STATUS = 2'd2
  } rsp_sel_e;

endpackage

// File: rtl/mem_bus_resp_uart_tx.sv
// uart_tx: 8N1 serializer, LSB first, idle high.
//   clk, rst : clock, synchronous active-high reset
//   data     : byte to send, taken when valid && ready
//   valid    : a byte is available
//   ready    : serializer can take a byte this cycle
//   tx       : registered serial line
module uart_tx
  import mem_bus_resp_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_end;
  logic          take;

  assign baud_end = (baud == BAUD_LAST);
  // Taking a byte on the last STOP cycle chains frames with no idle gap.
  assign ready    = (state == ST_IDLE) || ((state == ST_STOP) && baud_end);
  assign take     = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      if (state != ST_IDLE) baud <= baud_end ? '0 : baud + BW'(1);
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (take) begin
            shreg <= data;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            if (take) begin
              shreg <= data;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_resp.sv
// mem_bus_resp: byte-wide memory/IO responder for a memory controller.
//   clk, rst          : clock, synchronous active-high reset
//   mem_addr_i        : byte address (< IO_BASE -> RAM, else IO)
//   mem_din_i         : write data
//   mem_w_en_i        : 1 = write, 0 = read
//   mem_dout_o        : read data, one cycle after the address
//   uart_full_o       : TX FIFO has at most one free entry left
//   tx_o              : UART serial line
//   program_finish_o  : sticky halt flag, set by a write to IO_STATUS_ADDR
module mem_bus_resp
  import mem_bus_resp_pkg::*;
#(
  parameter int RAM_AW       = 17,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_din_i,
  input  logic        mem_w_en_i,
  output logic [7:0]  mem_dout_o,
  output logic        uart_full_o,
  output logic        tx_o,
  output logic        program_finish_o
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FCW = FAW + 1;

  mem_req_t req;
  logic     is_io;
  logic     ram_we;

  assign req    = '{addr: mem_addr_i, din: mem_din_i, w_en: mem_w_en_i};
  assign is_io  = (req.addr >= IO_BASE);
  assign ram_we = req.w_en && !is_io;

  // RAM: single port, read-before-write, output register only (no reset)
  // so it maps onto block RAM.
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ram_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[req.addr[RAM_AW-1:0]] <= req.din;
    ram_q <= ram[req.addr[RAM_AW-1:0]];
  end

  // TX FIFO
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [FCW-1:0] count, count_nxt;
  logic           fifo_empty, fifo_full;
  logic           push, pop;
  logic           tx_ready, tx_valid;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FCW'(FIFO_DEPTH));
  assign push       = req.w_en && (req.addr == IO_TX_ADDR) && !fifo_full;
  assign tx_valid   = !fifo_empty;
  assign pop        = tx_valid && tx_ready;
  assign count_nxt  = count + FCW'(push) - FCW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      uart_full_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FAW'(1);
      count       <= count_nxt;
      // Flag from the post-edge count so a write already in flight fits.
      uart_full_o <= (count_nxt >= FCW'(FIFO_DEPTH - 1));
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (fifo_mem[rd_ptr]),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx_o)
  );

  // Halt flag and read-data source select
  rsp_sel_e rsp_sel;
  logic     empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      program_finish_o <= 1'b0;
      rsp_sel          <= RSP_ZERO;
      empty_q          <= 1'b1;
    end else begin
      if (req.w_en && (req.addr == IO_STATUS_ADDR)) program_finish_o <= 1'b1;
      empty_q <= fifo_empty;
      if (req.w_en)                         rsp_sel <= RSP_ZERO;
      else if (!is_io)                      rsp_sel <= RSP_RAM;
      else if (req.addr == IO_STATUS_ADDR)  rsp_sel <= RSP_STATUS;
      else                                  rsp_sel <= RSP_ZERO;
    end
  end

  always_comb begin
    mem_dout_o = 8'h00;
    case (rsp_sel)
      RSP_RAM:    mem_dout_o = ram_q;
      RSP_STATUS: mem_dout_o = {7'b0, empty_q};
      default:    mem_dout_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_resp.sv
// tb_mem_bus_resp: directed self-checking bench for mem_bus_resp
// (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_mem_bus_resp;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [7:0]  din = '0;
  logic        we = 1'b0;
  logic [7:0]  dout;
  logic        full, tx, pf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q [$];
  logic [7:0] mon_b;

  always #5 clk = ~clk;

  mem_bus_resp #(.RAM_AW(17), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_addr_i       (addr),
    .mem_din_i        (din),
    .mem_w_en_i       (we),
    .mem_dout_o       (dout),
    .uart_full_o      (full),
    .tx_o             (tx),
    .program_finish_o (pf)
  );

  // Serial receiver: samples each bit near its middle and queues the byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (6) @(negedge clk);
        mon_b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (4) @(negedge clk);
        rx_q.push_back(mon_b);
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic w);
    addr = a; din = d; we = w;
    @(posedge clk); #1;
    addr = '0; din = '0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rx(input int n);
    for (int c = 0; c < 2000 && rx_q.size() < n; c++) @(posedge clk);
    #1;
    n_tests++;
    if (rx_q.size() !== n) begin
      n_fail++;
      $display("FAIL rx_count: got %0d bytes, expected %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_tests++; if (pf !== 1'b0) begin n_fail++; $display("FAIL reset_pf: got %b expected 0", pf); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_ram_rw;
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h12, 8'h34, 8'h56, 8'h78};
    bus(32'h10, 8'hA5, 1'b1);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL ram_write_dout: got %h expected 00", dout); end
    bus(32'h10, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL ram_raw: got %h expected a5", dout); end
    bus(32'h100, 8'h78, 1'b1);
    bus(32'h101, 8'h56, 1'b1);
    bus(32'h102, 8'h34, 1'b1);
    bus(32'h103, 8'h12, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus(32'h103 - i, 8'h00, 1'b0);
      n_tests++;
      if (dout !== exp_rd[i]) begin
        n_fail++; $display("FAIL ram_b2b[%0d]: got %h expected %h", i, dout, exp_rd[i]);
      end
    end
    bus(32'h10, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL ram_keep: got %h expected a5", dout); end
  endtask

  task automatic test_io_misc;
    rx_q.delete();
    bus(32'h30008, 8'h33, 1'b1);
    n_tests++; if (pf !== 1'b0) begin n_fail++; $display("FAIL io_other_wr_pf: got %b expected 0", pf); end
    bus(32'h30008, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL io_other_rd: got %h expected 00", dout); end
    bus(32'h30004, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL io_status_empty: got %h expected 01", dout); end
    idle(20);
    n_tests++; if (tx !== 1'b1 || rx_q.size() != 0) begin n_fail++; $display("FAIL io_no_tx: tx %b rx %0d, expected 1 and 0", tx, rx_q.size()); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    rx_q.delete();
    bus(32'h30000, 8'h55, 1'b1);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL tx_wr_dout: got %h expected 00", dout); end
    for (int i = 0; i < 10 * CPB; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (tx !== frame[i / CPB]) begin
        n_fail++; $display("FAIL tx_frame cycle %0d: got %b expected %b", i, tx, frame[i / CPB]);
      end
    end
    @(posedge clk); #1;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: got %b expected 1", tx); end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_fail++; $display("FAIL tx_rx_byte: got %0d bytes, expected one byte 55", rx_q.size());
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] b [10];
    for (int k = 0; k < 10; k++) b[k] = 8'hC0 + 8'(k * 3);
    rx_q.delete();
    // b[0] goes straight into the serializer; b[1..7] fill the FIFO to 7.
    for (int k = 0; k < 7; k++) bus(32'h30000, b[k], 1'b1);
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at6: got %b expected 0", full); end
    bus(32'h30000, b[7], 1'b1);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at7: got %b expected 1", full); end
    bus(32'h30000, b[8], 1'b1);
    bus(32'h30000, b[9], 1'b1);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at8: got %b expected 1", full); end
    bus(32'h30004, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL status_nonempty: got %h expected 00", dout); end
    wait_rx(9);
    idle(60);
    n_tests++; if (rx_q.size() != 9) begin n_fail++; $display("FAIL drop_9th: got %0d bytes, expected 9", rx_q.size()); end
    for (int k = 0; k < 9 && k < rx_q.size(); k++) begin
      n_tests++;
      if (rx_q[k] !== b[k]) begin n_fail++; $display("FAIL fifo_order[%0d]: got %h expected %h", k, rx_q[k], b[k]); end
    end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b expected 0", full); end
  endtask

  task automatic test_finish;
    rx_q.delete();
    bus(32'h30000, 8'hC3, 1'b1);
    bus(32'h30000, 8'h3C, 1'b1);
    bus(32'h30004, 8'h99, 1'b1);
    n_tests++; if (pf !== 1'b1) begin n_fail++; $display("FAIL pf_set: got %b expected 1", pf); end
    bus(32'h30004, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL pf_status_busy: got %h expected 00", dout); end
    wait_rx(2);
    n_tests++; if (pf !== 1'b1) begin n_fail++; $display("FAIL pf_sticky: got %b expected 1", pf); end
    bus(32'h30004, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL pf_status_drained: got %h expected 01", dout); end
    n_tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hC3 || rx_q[1] !== 8'h3C) begin
      n_fail++; $display("FAIL pf_bytes: got %0d bytes, expected c3 3c", rx_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic stayed_idle;
    for (int k = 0; k < 8; k++) bus(32'h30000, 8'h0F + 8'(k), 1'b1);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL mid_full_pre: got %b expected 1", full); end
    idle(6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: got %b expected 1", tx); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b expected 0", full); end
    n_tests++; if (pf !== 1'b0) begin n_fail++; $display("FAIL mid_pf: got %b expected 0", pf); end
    bus(32'h30004, 8'h00, 1'b0);
    n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL mid_empty: got %h expected 01", dout); end
    stayed_idle = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) stayed_idle = 1'b0;
    end
    n_tests++; if (stayed_idle !== 1'b1) begin n_fail++; $display("FAIL mid_discard: line left idle, expected idle high"); end
  endtask

  initial begin
    test_reset;
    test_ram_rw;
    test_io_misc;
    test_tx_frame;
    test_fifo_full;
    test_finish;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_resp.md
MEM_BUS_RESP -- requirements
Module: mem_bus_resp

Interface
REQ-001 Parameter RAM_AW, default 17: RAM byte-address width (128 KiB).
REQ-002 Parameter FIFO_DEPTH, default 8: UART TX FIFO entries (power of two, >=4).
REQ-003 Parameter CLKS_PER_BIT, default 434: clk cycles per serial bit.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_addr_i  input  32  byte address from memory controller.
REQ-007 mem_din_i  input  8  write data from controller.
REQ-008 mem_w_en_i  input  1  1 = write this cycle, 0 = read.
REQ-009 mem_dout_o  output  8  read data, registered.
REQ-010 uart_full_o  output  1  TX FIFO cannot safely accept another byte.
REQ-011 tx_o  output  1  serial UART line, 8N1, idle high.
REQ-012 program_finish_o  output  1  sticky halt flag.

Function
REQ-013 Decode: addr < 0x30000 = RAM, index addr[RAM_AW-1:0]; addr >= 0x30000 = IO.
REQ-014 RAM read: mem_dout_o SHALL equal RAM[addr] in the cycle after addr is presented with mem_w_en_i=0 (1-cycle latency, every cycle, no handshake).
REQ-015 RAM write: mem_w_en_i=1 writes mem_din_i to RAM[addr] at that edge; mem_dout_o for a write cycle is 0x00.
REQ-016 Read-after-write to same address in next cycle SHALL return new data.
REQ-017 IO write 0x30000: push mem_din_i into TX FIFO.
REQ-018 IO write 0x30004: set program_finish_o=1 (sticky until rst); data ignored.
REQ-019 IO read 0x30004: mem_dout_o = {7'b0, fifo_empty} next cycle; other IO reads return 0x00; other IO writes ignored.
REQ-020 uart_full_o registered; asserted when FIFO count >= FIFO_DEPTH-1 (one-entry slack for in-flight write).
REQ-021 Push to a completely full FIFO SHALL be dropped; FIFO contents and count unchanged.
REQ-022 Simultaneous push and pop in one cycle: count unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-023 Serializer states IDLE, START, DATA, STOP: IDLE with FIFO non-empty pops one byte and enters START in the same edge.
REQ-024 START drives 0, DATA drives bits LSB first, STOP drives 1, each for exactly CLKS_PER_BIT cycles; STOP returns to IDLE (back-to-back bytes without extra idle if FIFO non-empty).
REQ-025 Bit counter 3 bits, baud counter width clog2(CLKS_PER_BIT); byte frame = 10*CLKS_PER_BIT cycles.

Reset
REQ-026 On rst: mem_dout_o=0x00, uart_full_o=0, tx_o=1, program_finish_o=0, FIFO empty, serializer IDLE, counters 0.
REQ-027 rst mid-frame SHALL abort the frame, tx_o=1 next cycle; queued bytes discarded.
REQ-028 RAM contents are not reset (initialisation by file load only).

Structure
REQ-029 IO addresses (0x30000 base, 0x30004 status/halt) belong in consts.vh as shared defines.
REQ-030 Serializer SHALL be sub-module uart_tx (ports clk, rst, data, valid, ready, tx).
REQ-031 RAM inferred as single-port synchronous block RAM inside mem_bus_resp.

Verification
REQ-032 Write 0xA5 to 0x00010, then read 0x00010 -> mem_dout_o=0xA5 exactly one cycle after read addr.
REQ-033 Write bytes 0x78,0x56,0x34,0x12 to 0x100..0x103, read 0x103..0x100 back-to-back -> 0x12,0x34,0x56,0x78 on consecutive cycles.
REQ-034 Write 0x55 to 0x30000, CLKS_PER_BIT=4 -> tx_o: 0 for 4 cycles, bits 1,0,1,0,1,0,1,0 each 4 cycles, 1 for 4 cycles.
REQ-035 Push 7 bytes with serializer stalled (FIFO_DEPTH=8) -> uart_full_o=1; push 2 more -> 8th accepted, 9th dropped, 8 bytes transmitted in order.
REQ-036 Write to 0x30004 -> program_finish_o=1 next cycle, stays 1; read 0x30004 after FIFO drains -> 0x01.
REQ-037 Assert rst during DATA of a frame -> tx_o=1, FIFO empty, uart_full_o=0 after the reset edge.
